mbist_march_ctrl: RTL and testbench

- March C- MBIST controller sitting directly upstream of mem_wrapper.
- Drives mem_wrapper's test_mode, mbist_rd, mbist_wr, mbist_addr and mbist_din, and consumes mem_wrapper's mem_dout.
- On a start pulse it runs the full 10N March C- sequence over the 2^addr-word memory, compares every read, and reports pass/fail with first-failure capture.

---
 rtl/mbist_march_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: drives a mem_wrapper test port through the 10N
// March C- sequence and captures pass/fail with first-failure details.
module mbist_march_ctrl #(
    parameter int unsigned addr = 4,
    parameter int unsigned data = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [data-1:0] mem_dout,
    output logic            test_mode,
    output logic            mbist_rd,
    output logic            mbist_wr,
    output logic [addr-1:0] mbist_addr,
    output logic [data-1:0] mbist_din,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [addr-1:0] fail_addr,
    output logic [data-1:0] fail_exp,
    output logic [data-1:0] fail_got,
    output logic [7:0]      err_count
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [addr-1:0] IdxMax  = '1;
    localparam logic [2:0]      ElemLast = 3'd5;

    logic [1:0]      state_q, state_d;
    logic [2:0]      elem_q, elem_d;
    logic [addr-1:0] idx_q, idx_d;
    logic            phase_q, phase_d;

    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [addr-1:0] bus_addr_q, bus_addr_d;
    logic [data-1:0] din_q, din_d;
    logic [data-1:0] exp_q, exp_d;

    logic            cmp_vld_q, cmp_vld_d;
    logic [addr-1:0] cmp_addr_q, cmp_addr_d;
    logic [data-1:0] cmp_exp_q, cmp_exp_d;

    logic            done_q, done_d;
    logic            fail_q, fail_d;
    logic [addr-1:0] fail_addr_q, fail_addr_d;
    logic [data-1:0] fail_exp_q, fail_exp_d;
    logic [data-1:0] fail_got_q, fail_got_d;
    logic [7:0]      err_q, err_d;

    logic            two_op;
    logic            last_op;
    logic [2:0]      nxt_elem;
    logic [addr-1:0] nxt_idx;
    logic            nxt_phase;

    logic            issue;
    logic [2:0]      op_elem;
    logic [addr-1:0] op_idx;
    logic            op_phase;
    logic            op_rd;
    logic            rd_bg;
    logic            wr_bg;

    // Successor of the op currently on the bus.
    always_comb begin
        two_op  = (elem_q != 3'd0) && (elem_q != ElemLast);
        last_op = (elem_q == ElemLast) && (idx_q == IdxMax);
        nxt_elem  = elem_q;
        nxt_idx   = idx_q;
        nxt_phase = 1'b0;
        if (two_op && !phase_q) begin
            nxt_phase = 1'b1;
        end else if (idx_q == IdxMax) begin
            nxt_idx  = '0;
            nxt_elem = elem_q + 3'd1;
        end else begin
            nxt_idx = idx_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        err_d       = err_q;
        issue       = 1'b0;
        op_elem     = nxt_elem;
        op_idx      = nxt_idx;
        op_phase    = nxt_phase;

        // Read data for the previous read cycle is on mem_dout now.
        cmp_vld_d  = rd_q;
        cmp_addr_d = bus_addr_q;
        cmp_exp_d  = exp_q;
        if (cmp_vld_q && (mem_dout != cmp_exp_q)) begin
            fail_d = 1'b1;
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
            if (!fail_q) begin
                fail_addr_d = cmp_addr_q;
                fail_exp_d  = cmp_exp_q;
                fail_got_d  = mem_dout;
            end
        end

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StRun;
                    elem_d      = 3'd0;
                    idx_d       = '0;
                    phase_d     = 1'b0;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_got_d  = '0;
                    err_d       = 8'd0;
                    issue       = 1'b1;
                    op_elem     = 3'd0;
                    op_idx      = '0;
                    op_phase    = 1'b0;
                end
            end
            StRun: begin
                if (last_op) begin
                    state_d = StDrain;
                end else begin
                    elem_d  = nxt_elem;
                    idx_d   = nxt_idx;
                    phase_d = nxt_phase;
                    issue   = 1'b1;
                end
            end
            StDrain: begin
                state_d = StDone;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        op_rd = (op_elem != 3'd0) && !op_phase;
        rd_bg = (op_elem == 3'd2) || (op_elem == 3'd4);
        wr_bg = (op_elem == 3'd1) || (op_elem == 3'd3);

        rd_d       = 1'b0;
        wr_d       = 1'b0;
        bus_addr_d = '0;
        din_d      = '0;
        exp_d      = '0;
        if (issue) begin
            rd_d       = op_rd;
            wr_d       = !op_rd;
            // M3 and M4 walk the address space downwards.
            bus_addr_d = ((op_elem == 3'd3) || (op_elem == 3'd4)) ? ~op_idx : op_idx;
            din_d      = op_rd ? '0 : {data{wr_bg}};
            exp_d      = op_rd ? {data{rd_bg}} : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            elem_q      <= 3'd0;
            idx_q       <= '0;
            phase_q     <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            bus_addr_q  <= '0;
            din_q       <= '0;
            exp_q       <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_exp_q   <= '0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
            err_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            idx_q       <= idx_d;
            phase_q     <= phase_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            bus_addr_q  <= bus_addr_d;
            din_q       <= din_d;
            exp_q       <= exp_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_exp_q   <= cmp_exp_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
            err_q       <= err_d;
        end
    end

    assign busy       = (state_q == StRun) || (state_q == StDrain);
    assign test_mode  = busy;
    assign mbist_rd   = rd_q;
    assign mbist_wr   = wr_q;
    assign mbist_addr = bus_addr_q;
    assign mbist_din  = din_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign fail_addr  = fail_addr_q;
    assign fail_exp   = fail_exp_q;
    assign fail_got   = fail_got_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Scoreboard bench for mbist_march_ctrl: expected bus ops and results are queued
// at stimulus time and checked by a negedge monitor against a 16x8 memory model.
module tb_mbist_march_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;

    typedef struct packed {
        logic          tm;
        logic          bz;
        logic          rd;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;

    typedef struct packed {
        logic          f;
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        logic [DW-1:0] g;
        logic [7:0]    c;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] mem_dout = '0;
    logic          test_mode, mbist_rd, mbist_wr, busy, done, fail;
    logic [AW-1:0] mbist_addr, fail_addr;
    logic [DW-1:0] mbist_din, fail_exp, fail_got;
    logic [7:0]    err_count;

    logic [DW-1:0] mem [N];
    int            fault_mode = 0;
    op_t           op_q[$];
    res_t          res_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    logic          done_prev = 1'b0;

    always #5 clk = ~clk;

    mbist_march_ctrl #(.addr(AW), .data(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mem_dout   (mem_dout),
        .test_mode  (test_mode),
        .mbist_rd   (mbist_rd),
        .mbist_wr   (mbist_wr),
        .mbist_addr (mbist_addr),
        .mbist_din  (mbist_din),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_exp   (fail_exp),
        .fail_got   (fail_got),
        .err_count  (err_count)
    );

    function automatic logic [DW-1:0] inject(input logic [DW-1:0] v, input logic [AW-1:0] a);
        if (fault_mode == 1 && a == 4'd5) return v | 8'h01;
        if (fault_mode == 2 && a == 4'd15) return 8'h00;
        return v;
    endfunction

    // Registered-read memory model with optional stuck-at faults.
    always @(posedge clk) begin
        if (mbist_wr) mem[mbist_addr] <= mbist_din;
        if (mbist_rd) mem_dout <= inject(mem[mbist_addr], mbist_addr);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (mbist_rd || mbist_wr)) begin
            if (op_q.size() == 0)
                check("op_extra", {test_mode, busy, mbist_rd, mbist_wr, mbist_addr, mbist_din}, 0);
            else
                check("op_trace", {test_mode, busy, mbist_rd, mbist_wr, mbist_addr, mbist_din},
                      op_q.pop_front());
        end
        if (done && !done_prev) begin
            if (res_q.size() == 0)
                check("result_extra", {fail, fail_addr, fail_exp, fail_got, err_count}, 0);
            else
                check("result", {fail, fail_addr, fail_exp, fail_got, err_count},
                      res_q.pop_front());
        end
        done_prev <= done;
    end

    task automatic push_wr(input int a, input logic [DW-1:0] d);
        op_q.push_back(op_t'{1'b1, 1'b1, 1'b0, 1'b1, AW'(a), d});
    endtask

    task automatic push_rd(input int a);
        op_q.push_back(op_t'{1'b1, 1'b1, 1'b1, 1'b0, AW'(a), 8'h00});
    endtask

    task automatic push_ops();
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                int a;
                a = (e == 3 || e == 4) ? (N - 1 - k) : k;
                case (e)
                    0: push_wr(a, 8'h00);
                    1: begin push_rd(a); push_wr(a, 8'hFF); end
                    2: begin push_rd(a); push_wr(a, 8'h00); end
                    3: begin push_rd(a); push_wr(a, 8'hFF); end
                    4: begin push_rd(a); push_wr(a, 8'h00); end
                    default: push_rd(a);
                endcase
            end
        end
    endtask

    task automatic run(input int fm, input res_t exp_res, input bit extra, input int abort_at);
        int n;
        bit got_done;
        fault_mode = fm;
        push_ops();
        if (abort_at < 0) res_q.push_back(exp_res);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("clear_on_start", {done, fail, fail_addr, fail_exp, fail_got, err_count}, 0);
        check("busy_after_start", {busy, test_mode}, 2'b11);
        n = 0;
        got_done = 1'b0;
        while (n < 400 && !got_done) begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
            if (extra && (n == 40 || n == 160)) start = 1'b1;
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_outputs", {test_mode, busy, mbist_rd, mbist_wr, done}, 0);
                op_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            got_done = done;
        end
        start = 1'b0;
        check("done_latency", n, 161);
        @(negedge clk);
        @(negedge clk);
        check("ops_consumed", op_q.size(), 0);
        check("results_consumed", res_q.size(), 0);
    endtask

    initial begin
        res_t clean, sa1, sa0;
        clean = res_t'{1'b0, 4'd0, 8'h00, 8'h00, 8'd0};
        sa1   = res_t'{1'b1, 4'd5, 8'h00, 8'h01, 8'd3};
        sa0   = res_t'{1'b1, 4'd15, 8'hFF, 8'h00, 8'd2};

        repeat (3) @(negedge clk);
        check("reset_outputs", {test_mode, mbist_rd, mbist_wr, mbist_addr, mbist_din, busy, done,
                                fail, fail_addr, fail_exp, fail_got, err_count}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outputs", {test_mode, mbist_rd, mbist_wr, mbist_addr, mbist_din, busy, done,
                               fail, fail_addr, fail_exp, fail_got, err_count}, 0);

        run(0, clean, 1'b0, -1);
        run(1, sa1, 1'b0, -1);
        run(2, sa0, 1'b0, -1);
        run(0, clean, 1'b0, -1);
        run(0, clean, 1'b0, 70);
        run(0, clean, 1'b0, -1);
        run(0, clean, 1'b1, -1);
        repeat (3) @(negedge clk);
        check("done_held", {done, busy}, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
